// File: rtl/bias_stream_ctrl.sv
//==============================================================================
// Module      : bias_stream_ctrl
// Description : Reads NUM_CH bias words from a one-cycle-latency ROM, NUM_PIX
//               times over, and streams them to a FIFO-style output through a
//               2-entry skid buffer so back-pressure never drops a word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif
`ifndef KERN_S_K_19
`define KERN_S_K_19 16
`endif

module bias_stream_ctrl #(
    parameter int DATA_W  = `COEFF_WIDTH,
    parameter int NUM_CH  = `KERN_S_K_19,
    parameter int NUM_PIX = 1,
    parameter int ADDR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic [ADDR_W-1:0] bias_V_address0,
    output logic              bias_V_ce0,
    input  logic [DATA_W-1:0] bias_V_q0,
    output logic [DATA_W-1:0] output_V_din,
    input  logic              output_V_full_n,
    output logic              output_V_write
);

    localparam int c_PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [ADDR_W-1:0]  c_LAST_CH  = ADDR_W'(NUM_CH - 1);
    localparam logic [c_PIX_W-1:0] c_LAST_PIX = c_PIX_W'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ch;
    logic [c_PIX_W-1:0]  r_pix;
    logic                r_pend;       // a ROM read was issued last cycle
    logic [DATA_W-1:0]   r_mem0;
    logic [DATA_W-1:0]   r_mem1;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_pop;
    logic                w_ce0;
    logic                w_last_rd;
    logic                w_room;
    logic                w_drained;
    logic [DATA_W-1:0]   w_head;
    logic [1:0]          w_committed;

    assign w_pop       = (r_count != 2'd0) && output_V_full_n;
    assign w_head      = r_rd_ptr ? r_mem1 : r_mem0;
    assign w_last_rd   = (r_ch == c_LAST_CH) && (r_pix == c_LAST_PIX);
    // A word leaving this cycle frees its slot, which keeps reads back-to-back
    // while the output is flowing.
    assign w_committed = r_count + {1'b0, r_pend} - {1'b0, w_pop};
    assign w_room      = (w_committed < 2'd2);
    assign w_ce0       = (r_state == S_RUN) && w_room;
    // Entering DONE right after the final pop puts ap_done one cycle after
    // the last write.
    assign w_drained   = (r_count - {1'b0, w_pop} == 2'd0) && !r_pend;

    assign ap_idle         = (r_state == S_IDLE);
    assign ap_done         = (r_state == S_DONE);
    assign bias_V_ce0      = w_ce0;
    assign bias_V_address0 = r_ch;
    assign output_V_write  = w_pop;
    assign output_V_din    = (r_count != 2'd0) ? w_head : '0;

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ap_start only matters in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ap_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_ce0 && w_last_rd) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drained) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Channel/pixel counters advance once per issued read, clearing after the last
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_ch  <= '0;
            r_pix <= '0;
        end else if (w_ce0) begin
            if (w_last_rd) begin
                r_ch  <= '0;
                r_pix <= '0;
            end else if (r_ch == c_LAST_CH) begin
                r_ch  <= '0;
                r_pix <= r_pix + c_PIX_W'(1);
            end else begin
                r_ch  <= r_ch + ADDR_W'(1);
            end
        end
    end

    // Outstanding-read flag: ROM data lands one cycle after ce0
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_ce0;
        end
    end

    // 2-entry skid FIFO: push returning ROM data, pop on each stream write
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_mem0   <= '0;
            r_mem1   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_pend) begin
                if (r_wr_ptr) begin
                    r_mem1 <= bias_V_q0;
                end else begin
                    r_mem0 <= bias_V_q0;
                end
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bias_stream_ctrl.sv
//==============================================================================
// Module      : tb_bias_stream_ctrl
// Description : Self-checking bench for bias_stream_ctrl. A run-level model
//               (word index -> expected word, read/write counts, done timing)
//               is compared against two DUT instances every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bias_stream_ctrl;

    localparam int c_DW   = 16;
    localparam int c_NCH  = 4;
    localparam int c_NPX  = 3;
    localparam int c_TOT  = c_NCH * c_NPX;
    localparam int c_TOTB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // Instance A: 4 channels x 3 pixels, ROM = {10,11,12,13}
    logic            a_start = 1'b0;
    logic            a_full_n = 1'b1;
    logic            a_idle, a_done, a_ce0, a_write;
    logic [1:0]      a_addr;
    logic [c_DW-1:0] a_q0, a_din;

    // Instance B: 1 channel x 5 pixels, ROM = {7}
    logic            b_start = 1'b0;
    logic            b_full_n = 1'b1;
    logic            b_idle, b_done, b_ce0, b_write;
    logic [0:0]      b_addr;
    logic [c_DW-1:0] b_q0, b_din;

    bias_stream_ctrl #(.DATA_W(c_DW), .NUM_CH(c_NCH), .NUM_PIX(c_NPX)) u_dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(a_start),
        .ap_idle(a_idle), .ap_done(a_done),
        .bias_V_address0(a_addr), .bias_V_ce0(a_ce0), .bias_V_q0(a_q0),
        .output_V_din(a_din), .output_V_full_n(a_full_n), .output_V_write(a_write)
    );

    bias_stream_ctrl #(.DATA_W(c_DW), .NUM_CH(1), .NUM_PIX(c_TOTB)) u_dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(b_start),
        .ap_idle(b_idle), .ap_done(b_done),
        .bias_V_address0(b_addr), .bias_V_ce0(b_ce0), .bias_V_q0(b_q0),
        .output_V_din(b_din), .output_V_full_n(b_full_n), .output_V_write(b_write)
    );

    // ROMs with one cycle of read latency
    logic [c_DW-1:0] a_rom [0:3] = '{16'd10, 16'd11, 16'd12, 16'd13};
    always @(posedge clk) if (a_ce0) a_q0 <= a_rom[a_addr];
    always @(posedge clk) if (b_ce0) b_q0 <= 16'd7;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Run-level model state (written only by the monitor)
    int cyc = 0;
    bit a_busy = 0, a_done_due = 0;
    int a_wr = 0, a_rd = 0, a_raw = 0, a_start_cyc = 0, a_start_seen = 0, a_first_wr = -1;
    bit b_busy = 0, b_done_due = 0;
    int b_wr = 0, b_rd = 0, b_raw = 0;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        bit a_idle_now, b_idle_now;
        cyc++;
        a_idle_now = !a_busy && !a_done_due;
        b_idle_now = !b_busy && !b_done_due;

        // ---- instance A ----
        chk("a_done", a_done, a_done_due);
        chk("a_idle", a_idle, a_idle_now);
        chk("a_write", a_write, a_busy && a_full_n && (a_wr < c_TOT) && (cyc >= a_start_cyc + 2));
        if (a_idle_now) chk("a_din_idle", a_din, 0);
        if (a_busy && cyc == a_start_cyc) chk("a_first_ce0", {a_ce0, a_addr}, {1'b1, 2'b00});
        chk("a_ce0_legal", a_ce0 && !(a_busy && a_rd < c_TOT), 0);
        if (a_write) begin
            if (a_wr == 0) a_first_wr = cyc;
            chk("a_din", a_din, 10 + (a_wr % c_NCH));
            a_wr++;
        end
        if (a_ce0) begin
            chk("a_addr", a_addr, a_rd % c_NCH);
            a_rd++;
        end
        chk("a_buffered_le2", (a_rd - a_wr) <= 2, 1);
        a_raw += int'(a_write);

        // ---- instance B ----
        chk("b_done", b_done, b_done_due);
        chk("b_idle", b_idle, b_idle_now);
        chk("b_write_legal", b_write && !(b_busy && b_full_n && b_wr < c_TOTB), 0);
        if (b_write) begin
            chk("b_din", b_din, 7);
            b_wr++;
        end
        if (b_ce0) begin
            chk("b_addr", b_addr, 0);
            b_rd++;
        end
        chk("b_buffered_le2", (b_rd - b_wr) <= 2, 1);
        b_raw += int'(b_write);

        // ---- model update for the coming edge ----
        if (!rst_n) begin
            a_busy = 0; a_done_due = 0; a_wr = 0; a_rd = 0;
            b_busy = 0; b_done_due = 0; b_wr = 0; b_rd = 0;
        end else begin
            a_done_due = a_busy && a_write && (a_wr == c_TOT);
            if (a_done_due) a_busy = 0;
            else if (a_start && a_idle_now) begin
                a_busy = 1; a_wr = 0; a_rd = 0; a_raw = 0;
                a_start_cyc = cyc + 1; a_start_seen = cyc; a_first_wr = -1;
            end
            b_done_due = b_busy && b_write && (b_wr == c_TOTB);
            if (b_done_due) b_busy = 0;
            else if (b_start && b_idle_now) begin
                b_busy = 1; b_wr = 0; b_rd = 0; b_raw = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a_start;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic wait_a_done(input string nm);
        int n = 0;
        while (!a_done && n < 300) begin tick(); n++; end
        chk({nm, "_done_seen"}, a_done, 1);
        chk({nm, "_words"}, a_raw, c_TOT);
        tick();
        chk({nm, "_idle_after"}, a_idle, 1);
    endtask

    task automatic wait_a_words(input int n_words);
        int n = 0;
        while (a_wr < n_words && n < 300) begin tick(); n++; end
        chk("a_words_reached", a_wr >= n_words, 1);
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_idle", a_idle, 1);
        chk("rst_done", a_done, 0);
        chk("rst_ce0", a_ce0, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_write", a_write, 0);
        chk("rst_din", a_din, 0);
        rst_n = 1'b1;
        tick();

        // Free-flowing run: 10,11,12,13 x3, first write three cycles after start
        pulse_a_start();
        wait_a_done("run1");
        chk("run1_first_latency", a_first_wr - a_start_seen, 3);
        tick();

        // Stall for 5 cycles after the 2nd write
        pulse_a_start();
        wait_a_words(2);
        a_full_n = 1'b0;
        repeat (5) tick();
        chk("stall_ce0", a_ce0, 0);
        chk("stall_write", a_write, 0);
        chk("stall_buffered", a_rd - a_wr, 2);
        chk("stall_written", a_wr, 2);
        a_full_n = 1'b1;
        wait_a_done("run2");
        tick();

        // Start pulsed during RUN is ignored; a later start runs again
        pulse_a_start();
        tick(); tick();
        pulse_a_start();
        wait_a_done("run3");
        pulse_a_start();
        wait_a_done("run4");

        // Reset after the 5th write aborts the run
        pulse_a_start();
        wait_a_words(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_write", a_write, 0);
        chk("abort_idle", a_idle, 1);
        chk("abort_done", a_done, 0);
        repeat (5) tick();
        chk("abort_still_idle", a_idle, 1);
        pulse_a_start();
        wait_a_done("run5");

        // Output blocked from the start: buffer fills to 2, no progress
        a_full_n = 1'b0;
        pulse_a_start();
        repeat (20) tick();
        chk("block_ce0", a_ce0, 0);
        chk("block_idle", a_idle, 0);
        chk("block_done", a_done, 0);
        chk("block_reads", a_rd, 2);
        chk("block_writes", a_wr, 0);
        a_full_n = 1'b1;
        wait_a_done("run6");

        // Single channel, five pixels, full_n toggling every cycle
        begin
            int n = 0;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            while (!b_done && n < 200) begin
                b_full_n = ~b_full_n;
                tick();
                n++;
            end
            b_full_n = 1'b1;
            chk("b_done_seen", b_done, 1);
            chk("b_words", b_raw, c_TOTB);
            tick();
            chk("b_idle_after", b_idle, 1);
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
